// File: rtl/tile_map_ram.sv
// Tile bitmap store: H rows of W bits, two registered read ports, bulk row reload
// from an external source, single-bit clear with a running count of remaining 1 bits.
module tile_map_ram #(
    parameter int W  = 32,
    parameter int H  = 32,
    parameter int AW = 5,
    parameter int CW = 5,
    parameter int NW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    output logic [W-1:0]  out_a,
    output logic [W-1:0]  out_b,
    input  logic          reload,
    output logic [AW-1:0] init_addr,
    input  logic [W-1:0]  init_data,
    output logic          busy,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_row,
    input  logic [CW-1:0] clr_col,
    output logic          clr_hit,
    output logic [NW-1:0] dots_left,
    output logic          all_clear
);

    typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

    localparam logic [AW:0] H_L = H[AW:0];
    localparam logic [CW:0] W_L = W[CW:0];

    state_t          state_r;
    logic [W-1:0]    mem_r [H];
    logic [W-1:0]    out_a_r;
    logic [W-1:0]    out_b_r;
    logic [AW-1:0]   init_addr_r;
    logic [AW:0]     cnt_r;
    logic [NW-1:0]   dots_r;
    logic            busy_r;
    logic            clr_hit_r;

    logic            clr_ok_s;
    logic            clr_bit_s;
    logic [AW:0]     cnt_nx_s;
    logic [AW-1:0]   wr_row_s;

    function automatic logic [NW-1:0] popcount(input logic [W-1:0] v);
        logic [NW-1:0] n;
        n = {NW{1'b0}};
        for (int i = 0; i < W; i++) begin
            n = n + {{(NW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Clear qualification and load-sequencer arithmetic
    always_comb begin
        clr_ok_s  = 1'b0;
        clr_bit_s = 1'b0;
        if (clr_en && !busy_r && ({1'b0, clr_row} < H_L) && ({1'b0, clr_col} < W_L)) begin
            clr_ok_s  = 1'b1;
            clr_bit_s = mem_r[clr_row][clr_col];
        end else begin
            clr_ok_s  = 1'b0;
            clr_bit_s = 1'b0;
        end
        cnt_nx_s = cnt_r + {{AW{1'b0}}, 1'b1};
        // cnt_r counts LOAD cycles; the row written in cycle k was addressed in cycle k-1
        wr_row_s = cnt_r[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
    end

    // Storage, read ports, clear logic and IDLE/LOAD sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            for (int r = 0; r < H; r++) begin
                mem_r[r] <= {W{1'b0}};
            end
            out_a_r     <= {W{1'b0}};
            out_b_r     <= {W{1'b0}};
            init_addr_r <= {AW{1'b0}};
            cnt_r       <= {(AW+1){1'b0}};
            dots_r      <= {NW{1'b0}};
            busy_r      <= 1'b0;
            clr_hit_r   <= 1'b0;
        end else begin
            out_a_r   <= ({1'b0, addr_a} < H_L) ? mem_r[addr_a] : {W{1'b0}};
            out_b_r   <= ({1'b0, addr_b} < H_L) ? mem_r[addr_b] : {W{1'b0}};
            clr_hit_r <= 1'b0;
            if (clr_ok_s && clr_bit_s) begin
                mem_r[clr_row][clr_col] <= 1'b0;
                clr_hit_r               <= 1'b1;
                if (dots_r != {NW{1'b0}}) begin
                    dots_r <= dots_r - {{(NW-1){1'b0}}, 1'b1};
                end
            end
            case (state_r)
                IDLE: begin
                    init_addr_r <= {AW{1'b0}};
                    cnt_r       <= {(AW+1){1'b0}};
                    if (reload) begin
                        // A coincident clear still pulses clr_hit; the count restarts here
                        state_r <= LOAD;
                        busy_r  <= 1'b1;
                        dots_r  <= {NW{1'b0}};
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cnt_r != {(AW+1){1'b0}}) begin
                        mem_r[wr_row_s] <= init_data;
                        dots_r          <= dots_r + popcount(init_data);
                    end
                    if (cnt_r == H_L) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        init_addr_r <= {AW{1'b0}};
                        cnt_r       <= {(AW+1){1'b0}};
                    end else begin
                        cnt_r       <= cnt_nx_s;
                        init_addr_r <= (cnt_nx_s < H_L) ? cnt_nx_s[AW-1:0] : {AW{1'b0}};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out_a     = out_a_r;
    assign out_b     = out_b_r;
    assign init_addr = init_addr_r;
    assign busy      = busy_r;
    assign clr_hit   = clr_hit_r;
    assign dots_left = dots_r;
    assign all_clear = (dots_r == {NW{1'b0}}) && !busy_r;

endmodule

// File: tb/tb_tile_map_ram.sv
// Directed, table-driven bench for tile_map_ram at default geometry (32x32).
module tb_tile_map_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] out_a, out_b;
    logic        reload;
    logic [4:0]  init_addr;
    logic [31:0] init_data;
    logic        busy;
    logic        clr_en;
    logic [4:0]  clr_row;
    logic [4:0]  clr_col;
    logic        clr_hit;
    logic [10:0] dots_left;
    logic        all_clear;

    int checks = 0;
    int errors = 0;

    logic [31:0] src [32];

    tile_map_ram dut (
        .clk(clk), .reset(reset), .addr_a(addr_a), .addr_b(addr_b),
        .out_a(out_a), .out_b(out_b), .reload(reload), .init_addr(init_addr),
        .init_data(init_data), .busy(busy), .clr_en(clr_en), .clr_row(clr_row),
        .clr_col(clr_col), .clr_hit(clr_hit), .dots_left(dots_left), .all_clear(all_clear)
    );

    always #5 clk = ~clk;

    // External source: data for init_addr appears one cycle later
    always @(posedge clk) init_data <= src[init_addr];

    typedef struct {
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] ea;
        logic [31:0] eb;
    } rd_vec_t;

    typedef struct {
        logic [4:0]  row;
        logic [4:0]  col;
        logic        ehit;
        logic [10:0] edots;
    } clr_vec_t;

    rd_vec_t  rd_tab [5];
    clr_vec_t cl_tab [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rows(input logic [4:0] a, input logic [4:0] b,
                             input logic [31:0] ea, input logic [31:0] eb);
        addr_a = a;
        addr_b = b;
        tick();
        check("out_a", out_a, ea);
        check("out_b", out_b, eb);
    endtask

    // Full reload; optional coincident clear on reload cycle plus a clear attempt while busy
    task automatic do_load(input logic coincide, input logic [10:0] exp_dots);
        int cycles;
        reload = 1'b1;
        if (coincide) begin
            clr_en = 1'b1; clr_row = 5'd5; clr_col = 5'd2;
        end
        tick();
        reload = 1'b0;
        if (coincide) begin
            check("coincident_hit", {31'b0, clr_hit}, 32'd1);
            check("coincident_dots", {21'b0, dots_left}, 32'd0);
            clr_row = 5'd31; clr_col = 5'd0;
        end
        cycles = 0;
        while (busy && cycles < 60) begin
            check("init_addr", {27'b0, init_addr}, (cycles < 32) ? cycles : 0);
            reload = (cycles == 5) ? 1'b1 : 1'b0;
            tick();
            cycles++;
            if (coincide && cycles == 1) begin
                check("busy_clr_no_hit", {31'b0, clr_hit}, 32'd0);
                clr_en = 1'b0;
            end
        end
        reload = 1'b0;
        clr_en = 1'b0;
        check("busy_cycles", cycles, 32'd33);
        check("load_dots", {21'b0, dots_left}, {21'b0, exp_dots});
        check("load_all_clear", {31'b0, all_clear}, (exp_dots == 11'd0) ? 32'd1 : 32'd0);
    endtask

    task automatic do_clear(input logic [4:0] row, input logic [4:0] col,
                            input logic ehit, input logic [10:0] edots);
        clr_en = 1'b1; clr_row = row; clr_col = col;
        tick();
        clr_en = 1'b0;
        check("clr_hit", {31'b0, clr_hit}, {31'b0, ehit});
        check("clr_dots", {21'b0, dots_left}, {21'b0, edots});
    endtask

    initial begin
        int waits;
        rd_tab[0] = '{a: 5'd3,  b: 5'd31, ea: 32'd3,  eb: 32'd31};
        rd_tab[1] = '{a: 5'd0,  b: 5'd5,  ea: 32'd0,  eb: 32'h5};
        rd_tab[2] = '{a: 5'd16, b: 5'd15, ea: 32'd16, eb: 32'd15};
        rd_tab[3] = '{a: 5'd7,  b: 5'd7,  ea: 32'd7,  eb: 32'd7};
        rd_tab[4] = '{a: 5'd30, b: 5'd1,  ea: 32'd30, eb: 32'd1};
        cl_tab[0] = '{row: 5'd5,  col: 5'd0, ehit: 1'b0, edots: 11'd79};
        cl_tab[1] = '{row: 5'd0,  col: 5'd0, ehit: 1'b0, edots: 11'd79};
        cl_tab[2] = '{row: 5'd31, col: 5'd4, ehit: 1'b1, edots: 11'd78};
        cl_tab[3] = '{row: 5'd31, col: 5'd4, ehit: 1'b0, edots: 11'd78};
        cl_tab[4] = '{row: 5'd7,  col: 5'd1, ehit: 1'b1, edots: 11'd77};
        cl_tab[5] = '{row: 5'd8,  col: 5'd0, ehit: 1'b0, edots: 11'd77};
        for (int r = 0; r < 32; r++) src[r] = r;

        reset = 1'b1; reload = 1'b0; clr_en = 1'b0; clr_row = 5'd0; clr_col = 5'd0;
        addr_a = 5'd0; addr_b = 5'd0;
        #23;
        reset = 1'b0;

        // Reset state
        read_rows(5'd3, 5'd0, 32'd0, 32'd0);
        check("rst_dots", {21'b0, dots_left}, 32'd0);
        check("rst_all_clear", {31'b0, all_clear}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_init_addr", {27'b0, init_addr}, 32'd0);

        // Ramp load: row r = r, 80 ones total
        do_load(1'b0, 11'd80);
        for (int i = 0; i < 5; i++) read_rows(rd_tab[i].a, rd_tab[i].b, rd_tab[i].ea, rd_tab[i].eb);

        // Clear with simultaneous read of the same row returns pre-write data
        addr_a = 5'd5;
        do_clear(5'd5, 5'd0, 1'b1, 11'd79);
        check("prewrite_read", out_a, 32'h5);
        tick();
        check("postwrite_read", out_a, 32'h4);
        check("hit_one_cycle", {31'b0, clr_hit}, 32'd0);

        // Back-to-back clear of the same bit: only the first hits
        clr_en = 1'b1; clr_row = 5'd9; clr_col = 5'd3;
        tick();
        check("b2b_first_hit", {31'b0, clr_hit}, 32'd1);
        tick();
        clr_en = 1'b0;
        check("b2b_second_hit", {31'b0, clr_hit}, 32'd0);
        check("b2b_dots", {21'b0, dots_left}, 32'd78);
        for (int i = 0; i < 6; i++) do_clear(cl_tab[i].row, cl_tab[i].col, cl_tab[i].ehit, cl_tab[i].edots - 11'd1);
        read_rows(5'd31, 5'd9, 32'd15, 32'd1);

        // Reload with coincident clear, then a clear while busy
        do_load(1'b1, 11'd80);
        read_rows(5'd5, 5'd31, 32'h5, 32'd31);

        // Reset in the middle of a load
        reload = 1'b1;
        tick();
        reload = 1'b0;
        waits = 0;
        while (init_addr != 5'd10 && waits < 40) begin
            tick();
            waits++;
        end
        check("reach_addr10", {27'b0, init_addr}, 32'd10);
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_dots", {21'b0, dots_left}, 32'd0);
        check("midrst_out_a", out_a, 32'd0);
        check("midrst_init_addr", {27'b0, init_addr}, 32'd0);
        check("midrst_all_clear", {31'b0, all_clear}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        read_rows(5'd5, 5'd3, 32'd0, 32'd0);
        do_load(1'b0, 11'd80);

        // Single-bit map cleared to empty
        for (int r = 0; r < 32; r++) src[r] = 32'd0;
        src[2] = 32'h1;
        do_load(1'b0, 11'd1);
        read_rows(5'd2, 5'd5, 32'h1, 32'd0);
        do_clear(5'd2, 5'd0, 1'b1, 11'd0);
        check("final_all_clear", {31'b0, all_clear}, 32'd1);
        do_clear(5'd2, 5'd0, 1'b0, 11'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_map_ram.md
TILE_MAP_RAM -- requirements
Module: tile_map_ram

Interface
REQ-001 SHALL have parameter W, default 32, meaning bits (tiles) per row.
REQ-002 SHALL have parameter H, default 32, meaning row count.
REQ-003 SHALL have parameter AW, default 5, meaning row-address width, with H <= 2**AW.
REQ-004 SHALL have parameter CW, default 5, meaning column-index width, with W <= 2**CW.
REQ-005 SHALL have parameter NW, default 11, meaning dot-counter width, with W*H < 2**NW.
REQ-006 SHALL have one clock and an asynchronous, active-high reset, as follows:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr_a  in  AW  read port A row address.
- addr_b  in  AW  read port B row address.
- out_a  out  W  row data for addr_a, registered.
- out_b  out  W  row data for addr_b, registered.
- reload  in  1  single-cycle pulse; start row reload from the external source.
- init_addr  out  AW  row address presented to the external source.
- init_data  in  W  external row data, valid exactly 1 cycle after init_addr.
- busy  out  1  reload in progress.
- clr_en  in  1  request to clear one tile bit.
- clr_row  in  AW  row of the bit to clear.
- clr_col  in  CW  column of the bit to clear; bit index counts from LSB.
- clr_hit  out  1  1-cycle pulse; the requested bit was 1 and is now cleared.
- dots_left  out  NW  count of 1 bits in storage.
- all_clear  out  1  dots_left==0 and busy==0.

Function
REQ-007 SHALL store H rows of W bits each.
REQ-008 SHALL register out_a/out_b 1 cycle after the address.
- Read during a write to the same row returns the pre-write data.
REQ-009 SHALL implement the FSM states IDLE and LOAD.
- IDLE -> LOAD on reload=1; reload is ignored while in LOAD.
REQ-010 SHALL, in LOAD, drive init_addr = 0,1,...,H-1 on consecutive cycles.
- Row r is written with init_data the cycle after init_addr=r.
- LOAD -> IDLE after row H-1 is written; busy is high for exactly H+1 cycles.
REQ-011 SHALL hold busy=1 from the cycle after reload is accepted until the final row is written.
REQ-012 SHALL hold init_addr at 0 in IDLE.
REQ-013 SHALL set dots_left to 0 on the cycle LOAD is entered.
- It then adds popcount(init_data) for each row written.
- After LOAD, dots_left equals the total 1 bits loaded.
REQ-014 SHALL ignore clr_en while busy=1 or while clr_row >= H or clr_col >= W; no pulse, no change.
REQ-015 SHALL, on accepted clr_en:
- If bit [clr_row][clr_col] is 1, clear it, decrement dots_left by 1, and pulse clr_hit on the next cycle.
- If the bit is 0, change nothing.
REQ-016 SHALL never let dots_left wrap below 0.
REQ-017 SHALL give back-to-back clr_en to the same bit a hit only on the first cycle.
REQ-018 SHALL let clr_en arriving in the same cycle as reload from IDLE win for that cycle only.
- The clear applies and counts; LOAD then overwrites storage and resets the count.
REQ-019 SHALL derive all_clear combinationally from dots_left and busy.

Reset
REQ-020 SHALL, on reset assertion, immediately set:
- the FSM to IDLE;
- all storage rows, out_a, out_b, init_addr, dots_left, busy and clr_hit to 0;
- all_clear to 1.
REQ-021 SHALL, on reset mid-LOAD, abandon the load with no further init_addr sequencing.
- The next reload restarts from row 0.

Verification
REQ-022 SHALL pass: reset, then read addr_a=3 -> out_a=0, dots_left=0, all_clear=1.
REQ-023 SHALL pass: reload with a source returning row r = r (W=32) -> busy for 33 cycles, init_addr 0..31, dots_left=80, row 5 reads 32'h5.
REQ-024 SHALL pass: after REQ-023 load, clr_en row 5 col 0 -> clr_hit next cycle, dots_left=79, row 5 reads 32'h4; repeat -> no hit, dots_left=79.
REQ-025 SHALL pass: clr_en while busy, or with clr_col=0 on row 0 (value 0) -> no clr_hit, storage and count unchanged.
REQ-026 SHALL pass: reset asserted at init_addr=10 mid-load -> busy=0 and storage 0 immediately; new reload completes a full 33-cycle load.
REQ-027 SHALL pass: load a single-bit map (row 2 = 32'h1) and clear it -> dots_left=0, all_clear=1.
